// File: rtl/framebuffer_write_if.sv
// Stream-in / RAM-write-out bundle for the framebuffer write path.
// The write block sits on the slave side; the byte source and the RAM sit on the master side.
interface framebuffer_write_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  frame_start;
  logic [7:0]            data_in;
  logic                  data_valid;
  logic                  data_ready;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  ram_write_enable;
  logic                  ram_clk_enable;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output frame_start,
    output data_in,
    output data_valid,
    input  data_ready,
    input  ram_address,
    input  ram_data_out,
    input  ram_write_enable,
    input  ram_clk_enable,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  frame_start,
    input  data_in,
    input  data_valid,
    output data_ready,
    output ram_address,
    output ram_data_out,
    output ram_write_enable,
    output ram_clk_enable,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/framebuffer_write.sv
// Fills the scan-out framebuffer RAM from a raster-order byte stream, one write per pixel,
// using the fetch-side address layout {half, row, ~column}.
module framebuffer_write #(
  parameter int unsigned FBWRITE_PIXEL_WIDTH     = 64,
  parameter int unsigned FBWRITE_PIXEL_HEIGHT    = 16,
  parameter int unsigned FBWRITE_BYTES_PER_PIXEL = 2
) (
  input logic              clk_in,
  input logic              reset,
  framebuffer_write_if.slave fb
);

  localparam int unsigned XW   = $clog2(FBWRITE_PIXEL_WIDTH);
  // Row counter spans both halves, so its MSB is the half select.
  localparam int unsigned YW   = $clog2(FBWRITE_PIXEL_HEIGHT) + 1;
  localparam int unsigned AW   = XW + YW;
  localparam int unsigned BPP  = FBWRITE_BYTES_PER_PIXEL;
  localparam int unsigned DW   = BPP * 8;
  localparam int unsigned BIW  = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [BIW-1:0]   byte_idx_q, byte_idx_d;
  logic [DW-1:0]    pixel_q, pixel_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             we_q, we_d;

  logic             data_ready;
  logic             accept;
  logic             last_byte;
  logic             last_pixel;
  logic [DW-1:0]    assembled;

  assign data_ready = (state_q == StRecv) && !fb.frame_start;
  assign accept     = data_ready && fb.data_valid;
  assign last_byte  = (byte_idx_q == BIW'(BPP - 1));
  // Dimensions are powers of two, so the final column/row are all-ones.
  assign last_pixel = (&x_q) && (&y_q);

  // Merge the incoming byte into its lane; byte 0 lands in the top lane.
  always_comb begin
    assembled = pixel_q;
    for (int unsigned i = 0; i < BPP; i++) begin
      if (byte_idx_q == BIW'(i)) begin
        assembled[(BPP - 1 - i) * 8 +: 8] = fb.data_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    byte_idx_d = byte_idx_q;
    pixel_d    = pixel_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fb.frame_start) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (fb.frame_start) begin
          state_d = StRecv;
        end else if (accept && last_byte && last_pixel) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = fb.frame_start ? StRecv : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fb.frame_start) begin
      // Restart drops any half-assembled pixel; no write is issued for it.
      x_d        = '0;
      y_d        = '0;
      byte_idx_d = '0;
    end else if (accept) begin
      pixel_d = assembled;
      if (last_byte) begin
        byte_idx_d = '0;
        we_d       = 1'b1;
        addr_d     = {y_q, ~x_q};
        data_d     = assembled;
        if (&x_q) begin
          x_d = '0;
          y_d = y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end else begin
        byte_idx_d = byte_idx_q + BIW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      byte_idx_q <= '0;
      pixel_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      byte_idx_q <= byte_idx_d;
      pixel_q    <= pixel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  assign fb.data_ready       = data_ready;
  assign fb.ram_address      = addr_q;
  assign fb.ram_data_out     = data_q;
  assign fb.ram_write_enable = we_q;
  assign fb.busy             = (state_q != StIdle);
  assign fb.ram_clk_enable   = (state_q != StIdle);
  assign fb.frame_done       = (state_q == StDone);

endmodule

// File: tb/tb_framebuffer_write.sv
// Random-gap stream bench for framebuffer_write with a pixel-index reference model,
// plus a directed check of a one-byte-per-pixel instance.
module tb_framebuffer_write;

  localparam int unsigned W   = 64;
  localparam int unsigned H   = 16;
  localparam int unsigned BPP = 2;
  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 16;
  localparam int unsigned NPIX = 2 * W * H;

  typedef logic [AW+DW-1:0] wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framebuffer_write_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  framebuffer_write_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8))  bus1 ();

  framebuffer_write #(
    .FBWRITE_PIXEL_WIDTH    (W),
    .FBWRITE_PIXEL_HEIGHT   (H),
    .FBWRITE_BYTES_PER_PIXEL(BPP)
  ) dut (
    .clk_in(clk),
    .reset (rst),
    .fb    (bus)
  );

  framebuffer_write #(
    .FBWRITE_PIXEL_WIDTH    (W),
    .FBWRITE_PIXEL_HEIGHT   (H),
    .FBWRITE_BYTES_PER_PIXEL(1)
  ) dut1 (
    .clk_in(clk),
    .reset (rst),
    .fb    (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: pixel index n maps to row n/W, column n%W.
  logic          m_active = 1'b0;
  logic          m_done   = 1'b0;
  int            m_pix    = 0;
  int            m_nb     = 0;
  logic [63:0]   m_acc    = '0;
  logic          e_we     = 1'b0;
  logic [AW-1:0] e_addr   = '0;
  logic [DW-1:0] e_data   = '0;
  wr_t           m_log[$];

  function automatic logic [AW-1:0] pix_addr(input int p);
    int y;
    int x;
    y = p / W;
    x = p % W;
    return AW'(y * W + (W - 1 - x));
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0; m_done = 1'b0; m_pix = 0; m_nb = 0; m_acc = '0;
        e_we = 1'b0; e_addr = '0; e_data = '0;
      end else begin
        e_we = 1'b0;
        if (bus.frame_start) begin
          m_active = 1'b1; m_done = 1'b0; m_pix = 0; m_nb = 0; m_acc = '0;
        end else if (m_active) begin
          if (bus.data_valid) begin
            m_acc = (m_acc << 8) | 64'(bus.data_in);
            m_nb++;
            if (m_nb == BPP) begin
              e_we   = 1'b1;
              e_addr = pix_addr(m_pix);
              e_data = m_acc[DW-1:0];
              m_log.push_back({e_addr, e_data});
              m_pix++;
              m_nb  = 0;
              m_acc = '0;
              if (m_pix == NPIX) begin
                m_active = 1'b0;
                m_done   = 1'b1;
              end
            end
          end
        end else begin
          m_done = 1'b0;
        end
      end
    end
  end

  wr_t dut_log[$];
  int  wr_count = 0;
  int  done_cnt = 0;

  always @(negedge clk) begin
    chk("data_ready", 64'(bus.data_ready), 64'(m_active && !bus.frame_start));
    chk("busy", 64'(bus.busy), 64'(m_active || m_done));
    chk("ram_clk_enable", 64'(bus.ram_clk_enable), 64'(m_active || m_done));
    chk("frame_done", 64'(bus.frame_done), 64'(m_done));
    chk("ram_write_enable", 64'(bus.ram_write_enable), 64'(e_we));
    chk("ram_address", 64'(bus.ram_address), 64'(e_addr));
    chk("ram_data_out", 64'(bus.ram_data_out), 64'(e_data));
    if (bus.ram_write_enable === 1'b1) begin
      dut_log.push_back({bus.ram_address, bus.ram_data_out});
      wr_count++;
    end
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      bus.data_valid = 1'b0;
      tick();
    end
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, 64'(bus.ram_address), 64'h0);
    chk({tag, "_data"}, 64'(bus.ram_data_out), 64'h0);
    chk({tag, "_we"}, 64'(bus.ram_write_enable), 64'h0);
    chk({tag, "_done"}, 64'(bus.frame_done), 64'h0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'h0);
    chk({tag, "_ready"}, 64'(bus.data_ready), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wbase;
    int dbase;
    int waited;
    logic [15:0] v;

    bus.frame_start = 1'b0; bus.data_in = '0; bus.data_valid = 1'b0;
    bus1.frame_start = 1'b0; bus1.data_in = '0; bus1.data_valid = 1'b0;

    #3;
    check_outputs_zero("por");
    #4 rst = 1'b0;
    tick();

    // First pixel: 0x12, 0x34 back to back.
    start_frame();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    chk("px0_we_high", 64'(bus.ram_write_enable), 64'h1);
    chk("px0_addr", 64'(bus.ram_address), 64'h03F);
    chk("px0_data", 64'(bus.ram_data_out), 64'h1234);
    chk("model_px0", 64'(m_log[0]), 64'({11'h03F, 16'h1234}));
    tick();
    chk("px0_we_one_cycle", 64'(bus.ram_write_enable), 64'h0);

    // Async reset while a write is being presented.
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    chk("pre_reset_we", 64'(bus.ram_write_enable), 64'h1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    #3 rst = 1'b0;
    tick();

    // 64 random pixels with random gaps, then pixel 64 = 0xABCD at row 1.
    start_frame();
    base = dut_log.size();
    for (int p = 0; p < 64; p++) begin
      send_byte(8'($urandom), $urandom_range(0, 3));
      send_byte(8'($urandom), $urandom_range(0, 3));
    end
    send_byte(8'hAB, $urandom_range(0, 3));
    send_byte(8'hCD, $urandom_range(0, 3));
    tick();
    chk("row1_count", 64'(dut_log.size() - base), 64'd65);
    chk("row1_px64", 64'(dut_log[dut_log.size() - 1]), 64'({11'h07F, 16'hABCD}));
    chk("model_px64", 64'(m_log[m_log.size() - 1]), 64'({11'h07F, 16'hABCD}));

    // Restart mid-frame into a full frame: pixel n carries n.
    start_frame();
    base  = dut_log.size();
    wbase = m_log.size();
    dbase = done_cnt;
    for (int n = 0; n < int'(NPIX); n++) begin
      v = 16'(n);
      send_byte(v[15:8], $urandom_range(0, 3));
      if (n == int'(NPIX) - 1) begin
        bus.data_valid = 1'b1;
        bus.data_in    = v[7:0];
        tick();
        bus.data_valid = 1'b0;
      end else begin
        send_byte(v[7:0], $urandom_range(0, 3));
      end
    end
    waited = 0;
    while (bus.frame_done !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    chk("frame_done_timeout", 64'(waited), 64'd0);
    chk("last_we_with_done", 64'(bus.ram_write_enable), 64'h1);
    chk("last_addr", 64'(bus.ram_address), 64'h7C0);
    chk("last_data", 64'(bus.ram_data_out), 64'h07FF);
    tick();
    chk("frame_writes", 64'(dut_log.size() - base), 64'd2048);
    chk("px1024", 64'(dut_log[base + 1024]), 64'({11'h43F, 16'h0400}));
    chk("model_px1024", 64'(m_log[wbase + 1024]), 64'({11'h43F, 16'h0400}));
    chk("done_pulses", 64'(done_cnt - dbase), 64'd1);
    chk("busy_fell", 64'(bus.busy), 64'h0);
    base = dut_log.size();
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hEE;
    #1 chk("idle_not_ready", 64'(bus.data_ready), 64'h0);
    tick(); tick(); tick();
    bus.data_valid = 1'b0;
    chk("idle_no_writes", 64'(dut_log.size() - base), 64'd0);

    // Abort after the first byte of pixel 3; byte on the restart cycle is dropped.
    start_frame();
    base  = dut_log.size();
    dbase = done_cnt;
    for (int p = 0; p < 6; p++) send_byte(8'($urandom), $urandom_range(0, 3));
    send_byte(8'h55, 0);
    bus.frame_start = 1'b1;
    bus.data_valid  = 1'b1;
    bus.data_in     = 8'h99;
    tick();
    bus.frame_start = 1'b0;
    bus.data_valid  = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    tick();
    chk("abort_writes", 64'(dut_log.size() - base), 64'd4);
    chk("abort_restart_px", 64'(dut_log[dut_log.size() - 1]), 64'({11'h03F, 16'h0102}));
    chk("model_abort_px", 64'(m_log[m_log.size() - 1]), 64'({11'h03F, 16'h0102}));
    tick(); tick();
    chk("abort_no_done", 64'(done_cnt - dbase), 64'd0);

    // One byte per pixel: back-to-back writes.
    bus1.frame_start = 1'b1;
    tick();
    bus1.frame_start = 1'b0;
    bus1.data_valid  = 1'b1;
    bus1.data_in     = 8'h0A;
    tick();
    chk("bpp1_we0", 64'(bus1.ram_write_enable), 64'h1);
    chk("bpp1_addr0", 64'(bus1.ram_address), 64'h03F);
    chk("bpp1_data0", 64'(bus1.ram_data_out), 64'h0A);
    bus1.data_in = 8'h0B;
    tick();
    bus1.data_valid = 1'b0;
    chk("bpp1_we1", 64'(bus1.ram_write_enable), 64'h1);
    chk("bpp1_addr1", 64'(bus1.ram_address), 64'h03E);
    chk("bpp1_data1", 64'(bus1.ram_data_out), 64'h0B);
    tick();
    chk("bpp1_we_drop", 64'(bus1.ram_write_enable), 64'h0);
    chk("bpp1_busy", 64'(bus1.busy), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
